// File: rtl/axi_rd_arbiter.sv
// Two-master AXI read arbiter: 1-cycle arbitration in IDLE, grant locked for the whole burst, R beats steered to the owner.
// Stalls with the slave or owning master, no timeout. `AXI_RD_ARB_RR_EN selects round-robin ties; default gives master 1 fixed priority.
module axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          m_arvalid,
    output logic [1:0]          m_arready,
    input  logic [2*ADDR_W-1:0] m_araddr,
    input  logic [2*LEN_W-1:0]  m_arlen,
    output logic [1:0]          m_rvalid,
    input  logic [1:0]          m_rready,
    output logic [DATA_W-1:0]   m_rdata,
    output logic                m_rlast,
    output logic                s_arvalid,
    input  logic                s_arready,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic [LEN_W-1:0]    s_arlen,
    input  logic                s_rvalid,
    output logic                s_rready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic                s_rlast,
    output logic [1:0]          gnt
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t           state_q, state_d;
    logic [1:0]       gnt_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             own;
    logic             pick;
    logic             r_hs;
    logic             err_q;

    assign own = gnt[1];

`ifdef AXI_RD_ARB_RR_EN
    // Holds the owner of the last completed burst; the other master wins the next tie.
    logic rr_q;

    assign pick = (&m_arvalid) ? ~rr_q : m_arvalid[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_q <= 1'b1;
        else if (r_hs && s_rlast)
            rr_q <= own;
    end
`else
    assign pick = m_arvalid[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt     <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt     <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt;
        cnt_d     = cnt_q;
        m_arready = 2'b00;
        m_rvalid  = 2'b00;
        m_rdata   = '0;
        m_rlast   = 1'b0;
        s_arvalid = 1'b0;
        s_araddr  = '0;
        s_arlen   = '0;
        s_rready  = 1'b0;
        r_hs      = 1'b0;
        case (state_q)
            IDLE: begin
                if (|m_arvalid) begin
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                // Address tracks the live master input even if its valid drops early.
                s_arvalid      = m_arvalid[own];
                s_araddr       = own ? m_araddr[ADDR_W +: ADDR_W] : m_araddr[0 +: ADDR_W];
                s_arlen        = own ? m_arlen[LEN_W +: LEN_W] : m_arlen[0 +: LEN_W];
                m_arready[own] = s_arready;
                if (s_arvalid && s_arready) begin
                    cnt_d   = s_arlen;
                    state_d = DATA;
                end
            end
            DATA: begin
                m_rvalid[own] = s_rvalid;
                s_rready      = m_rready[own];
                m_rdata       = s_rdata;
                m_rlast       = s_rlast;
                r_hs          = s_rvalid && s_rready;
                if (r_hs) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (s_rlast) begin
                        gnt_d   = 2'b00;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky flag for a slave whose rlast disagrees with the requested length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (r_hs && (s_rlast != (cnt_q == '0)))
            err_q <= 1'b1;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && r_hs && !err_q && (s_rlast != (cnt_q == '0)))
            $error("axi_rd_arbiter: s_rlast disagrees with burst length");
    end
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboarded bench for axi_rd_arbiter: a memory model serves AR/R, expected ARs and beats are queued when requests are issued.
module tb_axi_rd_arbiter;
    logic        clk;
    logic        rst_n;
    logic        arv0, arv1;
    logic [31:0] a0, a1;
    logic [7:0]  l0, l1;
    logic        rdy0, rdy1;
    logic [1:0]  m_arready, m_rvalid, gnt;
    logic [31:0] m_rdata, s_araddr, s_rdata;
    logic        m_rlast, s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [7:0]  s_arlen;

    typedef struct { int m; logic [31:0] data; logic last; } rexp_t;
    typedef struct { logic [31:0] addr; logic [7:0] len; } arexp_t;
    rexp_t  rq[$];
    arexp_t arq[$];

    int n_tests = 0;
    int n_fail  = 0;
    bit r_toggle = 0;

    axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_arvalid({arv1, arv0}), .m_arready(m_arready),
        .m_araddr({a1, a0}), .m_arlen({l1, l0}),
        .m_rvalid(m_rvalid), .m_rready({rdy1, rdy0}),
        .m_rdata(m_rdata), .m_rlast(m_rlast),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rlast(s_rlast),
        .gnt(gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input int b);
        return ((a - 32'h1000) << 4) ^ (32'(b + 1) * 32'h11);
    endfunction

    // Memory model: accepts one AR at a time, returns len+1 beats, optional valid gaps.
    initial begin : slave
        bit ar_hs, r_hs, busy, phase;
        logic [31:0] sa, baddr;
        logic [7:0]  sl, blen;
        int beat;
        busy = 0; phase = 0; beat = 0; baddr = 0; blen = 0;
        s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rlast = 0;
        forever begin
            @(negedge clk);
            ar_hs = s_arvalid && s_arready;
            r_hs  = s_rvalid && s_rready;
            sa = s_araddr; sl = s_arlen;
            @(posedge clk); #1;
            if (!rst_n) begin
                busy = 0; phase = 0;
            end else begin
                if (r_hs) begin
                    if (beat == int'(blen)) busy = 0;
                    else beat++;
                end
                if (ar_hs) begin
                    busy = 1; baddr = sa; blen = sl; beat = 0;
                end
                phase = !phase;
            end
            s_arready = !busy;
            s_rvalid  = busy && (!r_toggle || phase || (s_rvalid && !r_hs));
            s_rdata   = busy ? mem_word(baddr, beat) : 32'h0;
            s_rlast   = busy && (beat == int'(blen));
        end
    end

    // Scoreboard: pop and compare every AR and R handshake.
    initial begin : monitor
        rexp_t  e;
        arexp_t ea;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (m_rvalid[i] && (i == 0 ? rdy0 : rdy1)) begin
                    n_tests++;
                    if (rq.size() == 0) begin
                        n_fail++;
                        $display("FAIL r_unexpected: m%0d data=%h, expected no beat", i, m_rdata);
                    end else begin
                        e = rq.pop_front();
                        if (e.m !== i || e.data !== m_rdata || e.last !== m_rlast) begin
                            n_fail++;
                            $display("FAIL r_beat: got m%0d data=%h last=%b, expected m%0d data=%h last=%b",
                                     i, m_rdata, m_rlast, e.m, e.data, e.last);
                        end
                    end
                end
            end
            if (s_arvalid && s_arready) begin
                n_tests++;
                if (arq.size() == 0) begin
                    n_fail++;
                    $display("FAIL ar_unexpected: addr=%h, expected no AR", s_araddr);
                end else begin
                    ea = arq.pop_front();
                    if (ea.addr !== s_araddr || ea.len !== s_arlen) begin
                        n_fail++;
                        $display("FAIL ar_order: got addr=%h len=%0d, expected addr=%h len=%0d",
                                 s_araddr, s_arlen, ea.addr, ea.len);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input int m, input logic [31:0] a, input logic [7:0] len);
        arq.push_back('{a, len});
        for (int b = 0; b <= int'(len); b++)
            rq.push_back('{m, mem_word(a, b), b == int'(len)});
    endtask

    task automatic do_req(input int m, input logic [31:0] addr, input logic [7:0] len, output int waited);
        int n;
        bit ok;
        n = 0; ok = 0;
        if (m == 0) begin arv0 = 1; a0 = addr; l0 = len; end
        else        begin arv1 = 1; a1 = addr; l1 = len; end
        while (!ok && n < 200) begin
            @(negedge clk);
            if (m_arready[m]) ok = 1;
            else n++;
        end
        waited = n;
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL ar_timeout m%0d: no m_arready after %0d cycles, expected acceptance", m, n);
        end
        @(posedge clk); #1;
        if (m == 0) arv0 = 0; else arv1 = 0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((rq.size() != 0 || arq.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (rq.size() != 0 || arq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d beats, %0d ARs outstanding after %0d cycles, expected 0", rq.size(), arq.size(), n);
        end
        @(negedge clk);
        n_tests++;
        if (gnt !== 2'b00) begin
            n_fail++;
            $display("FAIL gnt_idle: gnt=%b, expected 00", gnt);
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; arv0 = 1; arv1 = 1; a0 = 32'h1000; a1 = 32'h3000; l0 = 0; l1 = 0;
        rdy0 = 1; rdy1 = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if ({gnt, s_arvalid, m_arready, m_rvalid, s_rready} !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_outputs cyc%0d: gnt=%b s_arvalid=%b m_arready=%b m_rvalid=%b s_rready=%b, expected all 0",
                         k, gnt, s_arvalid, m_arready, m_rvalid, s_rready);
            end
        end
        n_tests++;
        if (s_araddr !== 32'h0 || s_arlen !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_addr: s_araddr=%h s_arlen=%h, expected 0", s_araddr, s_arlen);
        end
        @(posedge clk); #1;
        arv0 = 0; arv1 = 0;
        rst_n = 1;
    endtask

    task automatic test_single();
        int w;
        push_exp(0, 32'h1000, 8'd3);
        @(posedge clk); #1;
        do_req(0, 32'h1000, 8'd3, w);
        n_tests++;
        if (w !== 1) begin
            n_fail++;
            $display("FAIL single_latency: m_arready after %0d cycles, expected 1", w);
        end
        @(negedge clk);
        n_tests++;
        if (gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL single_gnt: gnt=%b, expected 01", gnt);
        end
        wait_drain();
    endtask

    task automatic test_tie();
        int w0, w1;
        apply_reset();
`ifdef AXI_RD_ARB_RR_EN
        for (int k = 0; k < 3; k++) begin
            push_exp(0, 32'h2000, 8'd0);
            push_exp(1, 32'h3000, 8'd0);
        end
`else
        for (int k = 0; k < 3; k++) push_exp(1, 32'h3000, 8'd0);
        for (int k = 0; k < 3; k++) push_exp(0, 32'h2000, 8'd0);
`endif
        @(posedge clk); #1;
        fork
            begin
                for (int k = 0; k < 3; k++) do_req(0, 32'h2000, 8'd0, w0);
            end
            begin
                for (int j = 0; j < 3; j++) do_req(1, 32'h3000, 8'd0, w1);
            end
        join
        wait_drain();
    endtask

    task automatic test_hold_off();
        int w0, w1, n;
        bit seen, early;
        push_exp(0, 32'h4000, 8'd7);
        push_exp(1, 32'h5000, 8'd0);
        r_toggle = 1;
        @(posedge clk); #1;
        do_req(0, 32'h4000, 8'd7, w0);
        repeat (2) @(posedge clk);
        #1;
        fork
            do_req(1, 32'h5000, 8'd0, w1);
            begin
                seen = 0; early = 0; n = 0;
                while (!seen && n < 200) begin
                    @(negedge clk);
                    n++;
                    if (m_arready[1]) early = 1;
                    if (m_rvalid[0] && rdy0 && m_rlast) seen = 1;
                end
                n_tests++;
                if (!seen || early) begin
                    n_fail++;
                    $display("FAIL hold_off: last_seen=%b early_arready=%b, expected 1 and 0", seen, early);
                end
                @(negedge clk);
                n_tests++;
                if (s_arvalid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL hold_off_idle: s_arvalid=%b one cycle after last beat, expected 0", s_arvalid);
                end
                @(negedge clk);
                n_tests++;
                if (s_arvalid !== 1'b1 || s_araddr !== 32'h5000) begin
                    n_fail++;
                    $display("FAIL hold_off_ar: s_arvalid=%b addr=%h two cycles after last beat, expected 1 and 00005000",
                             s_arvalid, s_araddr);
                end
            end
        join
        r_toggle = 0;
        wait_drain();
    endtask

    task automatic test_backpressure();
        int w, n, beats;
        push_exp(0, 32'h6000, 8'd7);
        @(posedge clk); #1;
        do_req(0, 32'h6000, 8'd7, w);
        n = 0; beats = 0;
        while (beats < 2 && n < 100) begin
            @(negedge clk);
            n++;
            if (m_rvalid[0] && rdy0) beats++;
        end
        @(posedge clk); #1;
        rdy0 = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_tests++;
            if (s_rready !== 1'b0 || s_rvalid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall cyc%0d: s_rready=%b s_rvalid=%b, expected 0 and 1", k, s_rready, s_rvalid);
            end
        end
        @(posedge clk); #1;
        rdy0 = 1;
        wait_drain();
    endtask

    task automatic test_reset_mid();
        int w, n, beats;
        push_exp(0, 32'h7000, 8'd3);
        @(posedge clk); #1;
        do_req(0, 32'h7000, 8'd3, w);
        n = 0; beats = 0;
        while (beats < 2 && n < 100) begin
            @(negedge clk);
            n++;
            if (m_rvalid[0] && rdy0) beats++;
        end
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        n_tests++;
        if ({gnt, m_arready, m_rvalid, s_arvalid, s_rready, m_rlast} !== 9'h000) begin
            n_fail++;
            $display("FAIL reset_mid_ctl: gnt=%b m_arready=%b m_rvalid=%b s_arvalid=%b s_rready=%b m_rlast=%b, expected all 0",
                     gnt, m_arready, m_rvalid, s_arvalid, s_rready, m_rlast);
        end
        n_tests++;
        if (m_rdata !== 32'h0 || s_araddr !== 32'h0 || s_arlen !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_mid_dat: m_rdata=%h s_araddr=%h s_arlen=%h, expected 0", m_rdata, s_araddr, s_arlen);
        end
        rq.delete();
        arq.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        push_exp(1, 32'h8000, 8'd1);
        @(posedge clk); #1;
        do_req(1, 32'h8000, 8'd1, w);
        n_tests++;
        if (w !== 1) begin
            n_fail++;
            $display("FAIL reset_mid_fresh: m_arready after %0d cycles, expected 1", w);
        end
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_hold_off();
        test_backpressure();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Two-master, one-slave AXI read-channel arbiter. It shares the single data-memory read port between the icache (master 0) and the dcache (master 1). It sits between the cache refill engines and `dmem`. It locks the grant for a full burst and routes R beats back to the owner. The write channel is not arbitrated here: the dcache owns it exclusively.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `LEN_W`, default 8: burst length field width; beats = len+1.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `m_arvalid`  in  2  per-master AR valid; bit i = master i.
- `m_arready`  out  2  per-master AR ready.
- `m_araddr`  in  2*ADDR_W  per-master address; master i in slice [i*ADDR_W +: ADDR_W].
- `m_arlen`  in  2*LEN_W  per-master burst length.
- `m_rvalid`  out  2  per-master R valid.
- `m_rready`  in  2  per-master R ready.
- `m_rdata`  out  DATA_W  R data, shared by both masters; qualified by `m_rvalid`.
- `m_rlast`  out  1  last beat, shared; qualified by `m_rvalid`.
- `s_arvalid`/`s_arready`/`s_araddr`/`s_arlen`  out/in/out/out  1/1/ADDR_W/LEN_W  AR to memory.
- `s_rvalid`/`s_rready`/`s_rdata`/`s_rlast`  in/out/in/in  1/1/DATA_W/1  R from memory.
- `gnt`  out  2  one-hot current owner; 0 when idle.

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any `m_arvalid` is set, pick a winner (policy under Configuration).
  - Register the winner in `gnt` and go to ADDR.
  - All ready/valid outputs are 0.
- ADDR:
  - `s_arvalid`/`s_araddr`/`s_arlen` are driven combinationally from the granted master.
  - `m_arready[g] = s_arready`.
  - On AR handshake, load beat counter = `s_arlen` and go to DATA.
- DATA:
  - `m_rvalid[g] = s_rvalid`; `s_rready = m_rready[g]`; `m_rdata`/`m_rlast` pass through.
  - The counter decrements on each R handshake.
  - On a handshake with `s_rlast`=1, clear `gnt`, update the priority state, and go to IDLE.
  - An `s_rlast` that disagrees with counter==0 sets sticky `err_q`. This is simulation-only: a `$error` is raised and no port carries it.
- The non-granted master always sees `m_arready`=0 and `m_rvalid`=0.
- A master's `m_arvalid` must stay high until accepted. Dropping it in ADDR is a protocol violation: the arbiter keeps driving the latched grant, and `s_araddr` follows the live input.
- Only one outstanding burst is allowed; no AR is accepted during DATA.

## Timing
- Reset (async assert, sync deassert by the system) puts:
  - the FSM in IDLE;
  - `gnt`=0, all `*valid`/`*ready` outputs 0, `s_araddr`/`s_arlen`=0;
  - the round-robin pointer on master 1.
- Arbitration adds exactly 1 cycle: `m_arvalid` rising in IDLE at edge N gives `s_arvalid`=1 after edge N+1.
- Back-to-back bursts:
  - the cycle after the last-beat handshake is IDLE;
  - the next `s_arvalid` appears 2 cycles after the last beat.
- Simultaneous requests in IDLE are resolved in the same cycle; the loser waits for the next IDLE.
- A request arriving during ADDR or DATA is held off, with no loss.
- Reset asserted mid-burst aborts immediately: outputs go to 0 asynchronously. `dmem` shares `rst_n` and abandons the burst too.
- Slave backpressure (`s_arready`=0 or `s_rvalid` gaps) stalls indefinitely with no timeout.

## Configuration
- `AXI_RD_ARB_RR_EN`:
  - Defined: round-robin. Priority goes to the master that did not own the last completed burst. After reset, master 0 has priority on a tie.
  - Undefined: fixed priority, master 1 (dcache) always wins ties. The pointer register is removed, and a continuously requesting dcache may starve the icache.

## Test plan
- Reset with both `m_arvalid`=1 and `rst_n`=0 → `gnt`=0, `s_arvalid`=0, and all `m_*valid`/`m_*ready` are 0 throughout reset.
- Master 0 alone, addr 0x0000_1000, len 3, memory returning words 0x11..0x44 → `s_arvalid` 1 cycle after request, 4 beats to master 0, `m_rlast` on beat 4, `m_rvalid[1]` stays 0, and `gnt` returns to 0.
- Both request from IDLE (m0 0x0000_2000, m1 0x0000_3000, len 0), repeated 3 times:
  - RR_EN: grants go m0, m1, m0.
  - Without RR_EN: m1 gets every grant while it requests.
- Master 1 requests during master 0's len-7 burst with `s_rvalid` toggling every other cycle → m1 sees no `m_arready` until m0's last beat, and its AR issues 2 cycles after that beat.
- `m_rready[0]`=0 for 5 cycles mid-burst → `s_rready`=0 for those cycles, with no beat dropped or duplicated.
- `rst_n` pulsed low after beat 2 of a len-3 burst → all outputs 0 within the same timestep, FSM in IDLE, and a fresh request is served normally.
